mp3dec_seq: RTL and testbench
=============================

MP3DEC_SEQ -- requirements
Module: mp3dec_seq

Interface
REQ-001 SHALL have parameter LW, default 10: FIFO level width in bits.
REQ-002 SHALL have parameter FRST_CYC, default 16: cycles fifo_rst is held high.
REQ-003 SHALL have parameter DRST_CYC, default 4: cycles dec_rst is held high after the FIFOs are ready.
REQ-004 SHALL have parameter TMO_CYC, default 1023: maximum cycles spent waiting on FIFO reset-busy.
REQ-005 SHALL have ports, in this order:
- Clk  in  1  sequencer clock (same domain as the decoder core);
- Rst  in  1  asynchronous, active-high reset;
- start  in  1  one-cycle request to begin decoding;
- stop  in  1  one-cycle request to halt decoding;
- wrrst_busy, rdrst_busy  in  1 each  FIFO reset-busy flags;
- ofifo_level  in  LW  output FIFO occupancy;
- ofifo_hi, ofifo_lo  in  LW each  pause and resume thresholds;
- invalid_format  in  1  decoder error flag;
- fifo_rst, dec_rst, dec_en  out  1 each  FIFO reset, decoder reset, decoder enable;
- busy  out  1  high in every state except IDLE and ERR;
- state  out  3  current state encoding;
- done_irq, err_irq  out  1 each  one-cycle event pulses.

Function
REQ-006 SHALL implement the states IDLE=0, FRST=1, FWAIT=2, DRST=3, RUN=4, PAUSE=5, ERR=6. All outputs SHALL be registered.
REQ-007 IDLE: fifo_rst=1, dec_rst=1, dec_en=0. On start, SHALL go to FRST.
REQ-008 FRST: fifo_rst SHALL be 1 for exactly FRST_CYC cycles, with the counter loaded on entry. SHALL then go to FWAIT, with fifo_rst=0 from the first FWAIT cycle.
REQ-009 FWAIT: when wrrst_busy=0 and rdrst_busy=0 in the same cycle, SHALL go to DRST on the next cycle.
REQ-010 DRST: dec_rst SHALL stay 1 for exactly DRST_CYC cycles. SHALL then go to RUN, with dec_rst=0 and dec_en=1 on RUN entry.
REQ-011 RUN: ofifo_level >= ofifo_hi SHALL cause a transition to PAUSE, with dec_en=0 on the next cycle.
REQ-012 PAUSE: ofifo_level <= ofifo_lo SHALL cause a transition back to RUN, with dec_en=1 on the next cycle. If ofifo_lo >= ofifo_hi, the block SHALL still behave deterministically: the pause check takes priority, so the block stays in PAUSE.
REQ-013 invalid_format in RUN or PAUSE SHALL cause a transition to ERR: dec_en=0, dec_rst=1, and err_irq pulses for exactly one cycle.
REQ-014 stop in any state from FRST through PAUSE SHALL cause a transition to IDLE on the next edge, restoring the IDLE outputs; done_irq pulses for one cycle only if the state was RUN or PAUSE.
REQ-015 ERR: start SHALL cause a transition to FRST; stop SHALL cause a transition to IDLE with no pulse.
REQ-016 Priority on coincident events SHALL be stop > invalid_format > start > threshold compares. start and stop together in IDLE: remain in IDLE.
REQ-017 start outside IDLE or ERR SHALL be ignored.
REQ-018 Threshold comparisons SHALL be unsigned, at LW bits. The counters SHALL be wide enough for max(FRST_CYC, TMO_CYC) and SHALL never wrap.

Reset
REQ-019 While Rst=1, the block SHALL hold: state=IDLE, fifo_rst=1, dec_rst=1, dec_en=0, busy=0, done_irq=0, err_irq=0, counters=0.
REQ-020 Rst asserted mid-operation SHALL take effect asynchronously, and no irq pulse SHALL be generated.

Configuration
REQ-021 Macro MP3DEC_SEQ_TIMEOUT_EN: when defined, a FWAIT stay exceeding TMO_CYC cycles SHALL cause a transition to ERR with an err_irq pulse. When undefined, FWAIT SHALL wait indefinitely and the timeout counter SHALL not be built.

Structure
REQ-022 The state encoding and the irq/state constants SHALL reside in package mp3dec_seq_pkg.
REQ-023 A single sub-module, mp3dec_seq_timer (loadable down-counter with a zero flag), SHALL be shared by FRST, DRST and the timeout function.

Verification
REQ-024 Rst release, start pulse, busy flags low: fifo_rst high 16 cycles, FWAIT 1 cycle, dec_rst high 4 cycles, dec_en=1, state=4.
REQ-025 RUN with ofifo_hi=900 and ofifo_lo=100: level 900 -> dec_en=0 and state=5; level 101 -> still PAUSE; level 100 -> state=4 and dec_en=1.
REQ-026 invalid_format during RUN -> state=6, err_irq a single-cycle pulse, dec_rst=1; subsequent start -> FRST sequence repeats.
REQ-027 stop and invalid_format asserted together during PAUSE -> state=0, done_irq=1 for one cycle, err_irq=0.
REQ-028 With MP3DEC_SEQ_TIMEOUT_EN defined, rdrst_busy stuck at 1 -> ERR after 1024 FWAIT cycles. Without the macro -> still FWAIT at cycle 5000.
REQ-029 Rst pulsed while in DRST -> outputs equal reset values within the same cycle, with no irq pulse.

Source files
------------

// File: rtl/mp3dec_seq_pkg.sv
// Shared state encoding, irq bit positions and per-state output decode for the MP3 decoder sequencer.
package mp3dec_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FRST  = 3'd1,
    ST_FWAIT = 3'd2,
    ST_DRST  = 3'd3,
    ST_RUN   = 3'd4,
    ST_PAUSE = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam int IRQ_W    = 2;
  localparam int IRQ_DONE = 0;
  localparam int IRQ_ERR  = 1;

  // {busy, fifo_rst, dec_rst, dec_en} for the state being entered
  function automatic logic [3:0] outs_of(state_t s);
    case (s)
      ST_IDLE:  outs_of = 4'b0110;
      ST_FRST:  outs_of = 4'b1110;
      ST_FWAIT: outs_of = 4'b1010;
      ST_DRST:  outs_of = 4'b1010;
      ST_RUN:   outs_of = 4'b1001;
      ST_PAUSE: outs_of = 4'b1000;
      ST_ERR:   outs_of = 4'b0010;
      default:  outs_of = 4'b0110;
    endcase
  endfunction

endpackage

// File: rtl/mp3dec_seq_timer.sv
// Loadable saturating down-counter with zero flag, shared by the FIFO reset, decoder reset and timeout phases.
module mp3dec_seq_timer #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                      r_cnt <= '0;
    else if (i_load)                r_cnt <= i_val;
    else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - ONE;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mp3dec_seq.sv
// MP3 decoder start/stop sequencer: FIFO reset, reset-busy wait, decoder reset, run/pause flow control.
// Optional FWAIT timeout enabled by defining MP3DEC_SEQ_TIMEOUT_EN.
module mp3dec_seq
  import mp3dec_seq_pkg::*;
#(
  parameter int LW       = 10,
  parameter int FRST_CYC = 16,
  parameter int DRST_CYC = 4,
  parameter int TMO_CYC  = 1023
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic          stop,
  input  logic          wrrst_busy,
  input  logic          rdrst_busy,
  input  logic [LW-1:0] ofifo_level,
  input  logic [LW-1:0] ofifo_hi,
  input  logic [LW-1:0] ofifo_lo,
  input  logic          invalid_format,
  output logic          fifo_rst,
  output logic          dec_rst,
  output logic          dec_en,
  output logic          busy,
  output logic [2:0]    state,
  output logic          done_irq,
  output logic          err_irq
);

  localparam int CMAX0 = (FRST_CYC > TMO_CYC) ? FRST_CYC : TMO_CYC;
  localparam int CMAX  = (CMAX0 > DRST_CYC) ? CMAX0 : DRST_CYC;
  localparam int TW    = $clog2(CMAX + 1);
  localparam logic [TW-1:0] FRST_LD = TW'(FRST_CYC - 1);
  localparam logic [TW-1:0] DRST_LD = TW'(DRST_CYC - 1);
`ifdef MP3DEC_SEQ_TIMEOUT_EN
  localparam logic [TW-1:0] TMO_LD  = TW'(TMO_CYC);
`endif

  state_t             r_st, w_nxt;
  logic               r_busy, r_fifo_rst, r_dec_rst, r_dec_en;
  logic [IRQ_W-1:0]   r_irq;
  logic               w_load, w_dec, w_zero, w_done, w_err;
  logic [TW-1:0]      w_ld_val;

  mp3dec_seq_timer #(.W(TW)) u_tmr (
    .i_clk (Clk),
    .i_rst (Rst),
    .i_load(w_load),
    .i_dec (w_dec),
    .i_val (w_ld_val),
    .o_zero(w_zero)
  );

  // Priority everywhere: stop > invalid_format > start > thresholds
  always_comb begin
    w_nxt    = r_st;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_ld_val = '0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    case (r_st)
      ST_IDLE: if (start && !stop) begin
        w_nxt = ST_FRST; w_load = 1'b1; w_ld_val = FRST_LD;
      end
      ST_FRST: begin
        if (stop) w_nxt = ST_IDLE;
        else if (w_zero) begin
          w_nxt = ST_FWAIT;
`ifdef MP3DEC_SEQ_TIMEOUT_EN
          w_load = 1'b1; w_ld_val = TMO_LD;
`endif
        end else w_dec = 1'b1;
      end
      ST_FWAIT: begin
        if (stop) w_nxt = ST_IDLE;
        else if (!wrrst_busy && !rdrst_busy) begin
          w_nxt = ST_DRST; w_load = 1'b1; w_ld_val = DRST_LD;
        end
`ifdef MP3DEC_SEQ_TIMEOUT_EN
        else if (w_zero) begin
          w_nxt = ST_ERR; w_err = 1'b1;
        end else w_dec = 1'b1;
`endif
      end
      ST_DRST: begin
        if (stop) w_nxt = ST_IDLE;
        else if (w_zero) w_nxt = ST_RUN;
        else w_dec = 1'b1;
      end
      ST_RUN: begin
        if (stop) begin w_nxt = ST_IDLE; w_done = 1'b1; end
        else if (invalid_format) begin w_nxt = ST_ERR; w_err = 1'b1; end
        else if (ofifo_level >= ofifo_hi) w_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop) begin w_nxt = ST_IDLE; w_done = 1'b1; end
        else if (invalid_format) begin w_nxt = ST_ERR; w_err = 1'b1; end
        else if (ofifo_level <= ofifo_lo && ofifo_level < ofifo_hi) w_nxt = ST_RUN;
      end
      ST_ERR: begin
        if (stop) w_nxt = ST_IDLE;
        else if (start) begin
          w_nxt = ST_FRST; w_load = 1'b1; w_ld_val = FRST_LD;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_st       <= ST_IDLE;
      r_busy     <= 1'b0;
      r_fifo_rst <= 1'b1;
      r_dec_rst  <= 1'b1;
      r_dec_en   <= 1'b0;
      r_irq      <= '0;
    end else begin
      r_st <= w_nxt;
      {r_busy, r_fifo_rst, r_dec_rst, r_dec_en} <= outs_of(w_nxt);
      r_irq[IRQ_DONE] <= w_done;
      r_irq[IRQ_ERR]  <= w_err;
    end
  end

  assign state    = r_st;
  assign busy     = r_busy;
  assign fifo_rst = r_fifo_rst;
  assign dec_rst  = r_dec_rst;
  assign dec_en   = r_dec_en;
  assign done_irq = r_irq[IRQ_DONE];
  assign err_irq  = r_irq[IRQ_ERR];

endmodule

// File: tb/tb_mp3dec_seq.sv
// Self-checking bench for mp3dec_seq: cycle model compared every cycle plus directed literal checks.
module tb_mp3dec_seq;

  localparam int LW = 10, FRST_CYC = 16, DRST_CYC = 4, TMO_CYC = 1023;

  logic Clk = 1'b0, Rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, wrrst_busy = 1'b0, rdrst_busy = 1'b0, invalid_format = 1'b0;
  logic [LW-1:0] ofifo_level = '0, ofifo_hi = 10'd900, ofifo_lo = 10'd100;
  logic fifo_rst, dec_rst, dec_en, busy, done_irq, err_irq;
  logic [2:0] state;

  int n_pass = 0, n_tot = 0, cyc = 0;

  mp3dec_seq #(.LW(LW), .FRST_CYC(FRST_CYC), .DRST_CYC(DRST_CYC), .TMO_CYC(TMO_CYC)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .stop(stop),
    .wrrst_busy(wrrst_busy), .rdrst_busy(rdrst_busy),
    .ofifo_level(ofifo_level), .ofifo_hi(ofifo_hi), .ofifo_lo(ofifo_lo),
    .invalid_format(invalid_format),
    .fifo_rst(fifo_rst), .dec_rst(dec_rst), .dec_en(dec_en), .busy(busy),
    .state(state), .done_irq(done_irq), .err_irq(err_irq)
  );

  always #5 Clk = ~Clk;

  // Model: state number plus cycles already spent in it; irq flags mark the edge that made the transition.
  logic [2:0] m_st = 3'd0;
  int         m_age = 0;
  logic       m_done = 1'b0, m_err = 1'b0;
  logic [4:0] m_nx;

  function automatic logic [4:0] mnext(input logic [2:0] st, input int age,
      input logic sta, input logic sto, input logic wb, input logic rb,
      input logic [LW-1:0] lvl, input logic [LW-1:0] hi, input logic [LW-1:0] lo, input logic inv);
    int s = int'(st);
    logic d = 1'b0, e = 1'b0;
    case (st)
      3'd0: if (sta && !sto) s = 1;
      3'd1: if (sto) s = 0; else if (age == FRST_CYC - 1) s = 2;
      3'd2: begin
        if (sto) s = 0;
        else if (!wb && !rb) s = 3;
`ifdef MP3DEC_SEQ_TIMEOUT_EN
        else if (age >= TMO_CYC) begin s = 6; e = 1'b1; end
`endif
      end
      3'd3: if (sto) s = 0; else if (age == DRST_CYC - 1) s = 4;
      3'd4: if (sto) begin s = 0; d = 1'b1; end
            else if (inv) begin s = 6; e = 1'b1; end
            else if (lvl >= hi) s = 5;
      3'd5: if (sto) begin s = 0; d = 1'b1; end
            else if (inv) begin s = 6; e = 1'b1; end
            else if (lvl >= hi) s = 5;
            else if (lvl <= lo) s = 4;
      3'd6: if (sto) s = 0; else if (sta) s = 1;
      default: s = 0;
    endcase
    return {s[2:0], d, e};
  endfunction

  always_comb m_nx = mnext(m_st, m_age, start, stop, wrrst_busy, rdrst_busy,
                           ofifo_level, ofifo_hi, ofifo_lo, invalid_format);

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_st <= 3'd0; m_age <= 0; m_done <= 1'b0; m_err <= 1'b0;
    end else begin
      m_st   <= m_nx[4:2];
      m_done <= m_nx[1];
      m_err  <= m_nx[0];
      m_age  <= (m_nx[4:2] != m_st) ? 0 : m_age + 1;
    end
  end

  function automatic logic [8:0] exp_vec();
    logic fr = (m_st == 3'd0 || m_st == 3'd1);
    logic dr = (m_st != 3'd4 && m_st != 3'd5);
    logic en = (m_st == 3'd4);
    logic bz = (m_st != 3'd0 && m_st != 3'd6);
    return {m_st, fr, dr, en, bz, m_done, m_err};
  endfunction

  task automatic tick();
    logic [8:0] act;
    @(negedge Clk);
    cyc++;
    act = {state, fifo_rst, dec_rst, dec_en, busy, done_irq, err_irq};
    n_tot++;
    if (act === exp_vec()) n_pass++;
    else $display("FAIL model cyc=%0d got=%b exp=%b (st,frst,drst,en,busy,done,err)", cyc, act, exp_vec());
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
  endtask

  task automatic wait_state(input int s, input string nm);
    int n = 0;
    while (int'(state) != s && n < 200) begin tick(); n++; end
    chk(nm, int'(state), s);
  endtask

  initial begin
    int n;
    Rst = 1'b1;
    tick(); tick();
    chk("rst_state", int'(state), 0);
    chk("rst_outs", int'({fifo_rst, dec_rst, dec_en, busy, done_irq, err_irq}), 'b110000);
    Rst = 1'b0;
    tick();

    start = 1'b1; stop = 1'b1; tick(); chk("start_stop_idle", int'(state), 0);
    start = 1'b0; stop = 1'b0; tick();

    // Bring-up: FRST 16, FWAIT 1, DRST 4, then RUN
    start = 1'b1; tick(); start = 1'b0;
    n = 0; while (state == 3'd1 && fifo_rst && n < 100) begin n++; tick(); end
    chk("frst_len", n, 16);
    chk("fwait_fifo_rst", int'(fifo_rst), 0);
    n = 0; while (state == 3'd2 && n < 100) begin n++; tick(); end
    chk("fwait_len", n, 1);
    n = 0; while (state == 3'd3 && dec_rst && n < 100) begin n++; tick(); end
    chk("drst_len", n, 4);
    chk("run_state", int'(state), 4);
    chk("run_dec_en", int'(dec_en), 1);

    // Flow control at 900/100
    ofifo_level = 10'd900; tick();
    chk("pause_state", int'(state), 5); chk("pause_dec_en", int'(dec_en), 0);
    ofifo_level = 10'd101; tick(); tick();
    chk("pause_101", int'(state), 5);
    ofifo_level = 10'd100; tick();
    chk("resume_state", int'(state), 4); chk("resume_dec_en", int'(dec_en), 1);
    start = 1'b1; tick(); chk("start_in_run", int'(state), 4); start = 1'b0;

    // Inverted thresholds: pause test wins while level >= hi
    ofifo_hi = 10'd50; ofifo_lo = 10'd60; ofifo_level = 10'd55; tick();
    chk("inv_thr_pause", int'(state), 5);
    tick(); chk("inv_thr_hold", int'(state), 5);
    ofifo_level = 10'd40; tick(); chk("inv_thr_resume", int'(state), 4);
    ofifo_hi = 10'd900; ofifo_lo = 10'd100; ofifo_level = 10'd0;

    // Format error in RUN, then restart from ERR
    invalid_format = 1'b1; tick(); invalid_format = 1'b0;
    chk("err_state", int'(state), 6); chk("err_irq_hi", int'(err_irq), 1); chk("err_dec_rst", int'(dec_rst), 1);
    tick(); chk("err_irq_lo", int'(err_irq), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_frst", int'(state), 1);
    wait_state(4, "restart_run");

    // stop + invalid_format together in PAUSE
    ofifo_level = 10'd900; tick(); chk("pause2", int'(state), 5);
    stop = 1'b1; invalid_format = 1'b1; tick(); stop = 1'b0; invalid_format = 1'b0;
    chk("stop_inv_state", int'(state), 0); chk("stop_done", int'(done_irq), 1); chk("stop_no_err", int'(err_irq), 0);
    ofifo_level = 10'd0; tick(); chk("done_one_cyc", int'(done_irq), 0);

    // stop during FRST: no done pulse
    start = 1'b1; tick(); start = 1'b0; tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_frst_state", int'(state), 0); chk("stop_frst_done", int'(done_irq), 0);

    // FWAIT holds while either busy flag is set
    wrrst_busy = 1'b1; start = 1'b1; tick(); start = 1'b0;
    wait_state(2, "fwait_enter");
    repeat (5) tick(); chk("fwait_wr_busy", int'(state), 2);
    wrrst_busy = 1'b0; rdrst_busy = 1'b1; tick(); chk("fwait_rd_busy", int'(state), 2);
    rdrst_busy = 1'b0; tick(); chk("drst_enter", int'(state), 3);

    // Asynchronous reset mid-DRST
    tick(); chk("still_drst", int'(state), 3);
    #2 Rst = 1'b1; #1;
    chk("arst_state", int'(state), 0);
    chk("arst_outs", int'({fifo_rst, dec_rst, dec_en, busy, done_irq, err_irq}), 'b110000);
    tick(); Rst = 1'b0; tick();

    // FWAIT with rdrst_busy stuck
    rdrst_busy = 1'b1; start = 1'b1; tick(); start = 1'b0;
    wait_state(2, "stuck_fwait");
    n = 0; while (state == 3'd2 && n < 5000) begin n++; tick(); end
`ifdef MP3DEC_SEQ_TIMEOUT_EN
    chk("tmo_len", n, 1024); chk("tmo_state", int'(state), 6); chk("tmo_err_irq", int'(err_irq), 1);
`else
    chk("no_tmo_len", n, 5000); chk("no_tmo_state", int'(state), 2);
`endif
    rdrst_busy = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    chk("final_idle", int'(state), 0); chk("final_no_done", int'(done_irq), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
